// File: rtl/mac_accum_stage.sv
// mac_accum_stage: accumulates COUNT unsigned 8-bit products into an ACC_W-bit
// sum, then drains the sum LSB-first as ACC_W/8 byte beats.
// Optional build macro: SATURATE_EN (clamp on overflow instead of wrapping).
//
// Handshakes: a beat moves on a port only in a cycle where valid and ready are
// both high at the rising edge. in_ready/out_valid depend only on registered
// state, so there is no combinational path from out_ready to in_ready.

module mac_accum_stage #(
    parameter int ACC_W = 16,
    parameter int COUNT = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] prod_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       ovf,
    output logic       busy,
    output logic       state_dbg
);

    localparam int NB     = ACC_W / 8;
    localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0]  COUNT_C   = CNT_W'(COUNT);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic [BEAT_W-1:0]  beat;
    logic               ovf_q;

    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   count_inc;
    logic               last_beat;
    logic [7:0]         beat_byte;

    // Next accumulator value: true sum with carry, then wrap or clamp.
    always_comb begin
        sum_ext   = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_in};
        carry     = sum_ext[ACC_W];
        count_inc = count + CNT_W'(1);
`ifdef SATURATE_EN
        // Once clamped at all-ones, any further nonzero add carries again,
        // so the value stays pinned for the rest of the accumulation.
        acc_next  = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_next  = sum_ext[ACC_W-1:0];
`endif
    end

    // Select the byte of the accumulator addressed by the current beat.
    always_comb begin
        beat_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (beat == BEAT_W'(i)) begin
                beat_byte = acc[8*i +: 8];
            end
        end
    end

    assign last_beat = (beat == LAST_BEAT);
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? beat_byte : 8'h00;
    assign out_last  = out_valid & last_beat;
    assign ovf       = ovf_q;
    assign busy      = (count != '0) | out_valid;
    assign state_dbg = state;

    // Control FSM and datapath registers; clear overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
            acc   <= '0;
            count <= '0;
            beat  <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            state <= ST_ACCUM;
            acc   <= '0;
            count <= '0;
            beat  <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        count <= count_inc;
                        ovf_q <= ovf_q | carry;
                        if (count_inc == COUNT_C) begin
                            state <= ST_DRAIN;
                            beat  <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (last_beat) begin
                            state <= ST_ACCUM;
                            acc   <= '0;
                            count <= '0;
                            beat  <= '0;
                            ovf_q <= 1'b0;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Bench for mac_accum_stage: instance A uses default parameters, instance B
// uses ACC_W=8, COUNT=2 for the single-beat overflow cases. 'sel' picks which
// instance the shared driver tasks talk to.

module tb_mac_accum_stage;

    logic       clk;
    logic       rst_n;
    logic [7:0] prod_in;
    logic       in_valid;
    logic       clear;
    logic       out_ready;
    logic       sel;

    logic       a_in_ready, a_out_valid, a_out_last, a_ovf, a_busy, a_state;
    logic [7:0] a_out_data;
    logic       b_in_ready, b_out_valid, b_out_last, b_ovf, b_busy, b_state;
    logic [7:0] b_out_data;

    logic       obs_in_ready, obs_out_valid, obs_out_last, obs_ovf, obs_busy, obs_state;
    logic [7:0] obs_out_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] prod_q[$];
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mac_accum_stage #(.ACC_W(16), .COUNT(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .clear(clear),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready & ~sel), .out_last(a_out_last),
        .ovf(a_ovf), .busy(a_busy), .state_dbg(a_state)
    );

    mac_accum_stage #(.ACC_W(8), .COUNT(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .clear(clear),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready & sel), .out_last(b_out_last),
        .ovf(b_ovf), .busy(b_busy), .state_dbg(b_state)
    );

    assign obs_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign obs_out_valid = sel ? b_out_valid : a_out_valid;
    assign obs_out_last  = sel ? b_out_last  : a_out_last;
    assign obs_out_data  = sel ? b_out_data  : a_out_data;
    assign obs_ovf       = sel ? b_ovf       : a_ovf;
    assign obs_busy      = sel ? b_busy      : a_busy;
    assign obs_state     = sel ? b_state     : a_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: whole-result arithmetic from the list of accepted products.
    task automatic compute_expected();
        longint sum;
        longint lim;
        longint val;
        int     w;
        w   = sel ? 8 : 16;
        sum = 0;
        foreach (prod_q[i]) sum += prod_q[i];
        lim = longint'(1) << w;
        exp_ovf = (sum >= lim);
`ifdef SATURATE_EN
        val = exp_ovf ? lim - 1 : sum;
`else
        val = sum % lim;
`endif
        exp_q.delete();
        for (int i = 0; i < w / 8; i++) exp_q.push_back(8'((val >> (8 * i)) & 8'hFF));
        prod_q.delete();
    endtask

    // Driver: present one product for one accepted cycle, then idle 'gap' cycles.
    task automatic feed(input logic [7:0] p, input int gap);
        in_valid = 1'b1;
        prod_in  = p;
        tick();
        in_valid = 1'b0;
        prod_q.push_back(p);
        repeat (gap) tick();
    endtask

    // Drain and score every beat, with random backpressure up to max_stall.
    task automatic drain(input int max_stall);
        int n;
        int nb;
        compute_expected();
        nb = exp_q.size();
        for (int i = 0; i < nb; i++) begin
            n = 0;
            while (!obs_out_valid && n < 20) begin
                tick();
                n++;
            end
            check("out_valid", obs_out_valid, 1);
            out_ready = 1'b0;
            repeat ($urandom_range(0, max_stall)) tick();
            check("out_data", obs_out_data, exp_q[i]);
            check("out_last", obs_out_last, (i == nb - 1));
            check("ovf", obs_ovf, exp_ovf);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("post_drain_valid", obs_out_valid, 0);
        check("post_drain_in_ready", obs_in_ready, 1);
        check("post_drain_busy", obs_busy, 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; prod_in = 8'h00; in_valid = 1'b0; clear = 1'b0;
        out_ready = 1'b0; sel = 1'b0;

        // Reset state.
        #12;
        check("rst_in_ready", obs_in_ready, 1);
        check("rst_out_valid", obs_out_valid, 0);
        check("rst_out_last", obs_out_last, 0);
        check("rst_out_data", obs_out_data, 0);
        check("rst_ovf", obs_ovf, 0);
        check("rst_busy", obs_busy, 0);
        check("rst_state", obs_state, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Four 0xE1 back-to-back: 0x0384.
        for (int k = 0; k < 4; k++) feed(8'hE1, 0);
        check("t1_in_ready_drop", obs_in_ready, 0);
        check("t1_valid_next", obs_out_valid, 1);
        drain(0);

        // Backpressure; products offered during DRAIN must be ignored.
        for (int k = 1; k <= 4; k++) feed(8'(k), 0);
        in_valid = 1'b1; prod_in = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", obs_out_valid, 1);
            check("bp_data", obs_out_data, 8'h0A);
            check("bp_last", obs_out_last, 0);
            tick();
        end
        in_valid = 1'b0;
        drain(0);

        // Gapped input; busy from first accept until final beat.
        feed(8'h10, 0);
        check("gap_busy", obs_busy, 1);
        tick();
        feed(8'h10, 1);
        feed(8'h10, 1);
        feed(8'h10, 0);
        check("gap_busy_drain", obs_busy, 1);
        drain(2);

        // clear mid-accumulation drops the concurrent product.
        feed(8'h05, 0);
        feed(8'h05, 0);
        in_valid = 1'b1; prod_in = 8'h07; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        prod_q.delete();
        check("clr_busy", obs_busy, 0);
        check("clr_in_ready", obs_in_ready, 1);
        for (int k = 0; k < 4; k++) feed(8'h01, 0);
        drain(1);

        // clear mid-drain abandons the result.
        for (int k = 0; k < 4; k++) feed(8'($urandom_range(0, 255)), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        prod_q.delete();
        check("clr_drain_valid", obs_out_valid, 0);
        check("clr_drain_busy", obs_busy, 0);

        // Single-beat overflow instance.
        sel = 1'b1;
        feed(8'hE1, 0);
        feed(8'hE1, 0);
        drain(0);

        // Randomized rounds on both instances.
        for (int r = 0; r < 16; r++) begin
            sel = r[0];
            for (int k = 0; k < (sel ? 2 : 4); k++)
                feed(8'($urandom_range(0, 255)), $urandom_range(0, 2));
            drain(3);
        end

        // Asynchronous reset between edges while draining.
        sel = 1'b0;
        for (int k = 0; k < 4; k++) feed(8'hAA, 0);
        check("ar_pre_valid", obs_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", obs_out_valid, 0);
        check("ar_in_ready", obs_in_ready, 1);
        check("ar_busy", obs_busy, 0);
        prod_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) feed(8'h01, 0);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
